fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of PC and instruction words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  suppresses new fetches while high.
REQ-006 SHALL have port halt_req  input  1  stop fetching until the next redirect.
REQ-007 SHALL have port redir_valid  input  1  flush and redirect fetch (branch/jump taken).
REQ-008 SHALL have port redir_target  input  ADDR_WIDTH  new fetch address.
REQ-009 SHALL have port PC  output  ADDR_WIDTH  word address to instruction memory; memory read is combinational.
REQ-010 SHALL have port instr  input  ADDR_WIDTH  instruction returned by memory for PC in the same cycle.
REQ-011 SHALL have port out_valid  output  1  head buffer entry valid to decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-013 SHALL have port out_instr  output  ADDR_WIDTH  head instruction.
REQ-014 SHALL have port out_pc  output  ADDR_WIDTH  PC of head instruction.
REQ-015 SHALL have port misalign  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-016 SHALL implement states BOOT, RUN and HALTED; BOOT lasts exactly one cycle after reset release, then RUN, with no fetch in BOOT.
REQ-017 SHALL hold a 2-entry in-order buffer of {instr, pc}, with count in 0..2.
REQ-018 SHALL define pop = out_valid && out_ready, and fetch = (state==RUN) && !stall && !redir_valid && (count<2 || pop).
REQ-019 SHALL, on fetch, write {instr, PC} at the tail and set PC <= PC+4 modulo 2^ADDR_WIDTH (32'hFFFF_FFFC wraps to 0).
REQ-020 SHALL drive out_valid = (count!=0), with out_instr/out_pc from the head and unregistered.
REQ-021 SHALL, for fetch and pop in the same cycle, leave count unchanged and preserve order; at count==2, pop frees the slot for the same-cycle fetch.
REQ-022 SHALL, on redir_valid, give redirect priority over stall, halt_req and fetch: count <= 0, PC <= {redir_target[ADDR_WIDTH-1:2], 2'b00}, and state <= RUN from RUN or HALTED.
REQ-023 SHALL, on redir_valid with redir_target[1:0]!=0, set misalign to 1; misalign clears only on reset.
REQ-024 SHALL, on redir_valid in BOOT, apply the redirect, with the state still moving BOOT->RUN.
REQ-025 SHALL, on redir_valid and pop in the same cycle, retire the popped entry and flush the remaining entries; the entry fetched in the cycle after a redirect is from the target address.
REQ-026 SHALL, on halt_req in RUN without redir_valid, go to HALTED with no fetch that cycle; buffered entries still drain via pop.
REQ-027 SHALL, when stall is high, block fetches only; pops proceed.
REQ-028 SHALL hold PC and buffer contents unchanged when no fetch occurs.

Reset
REQ-029 SHALL, on rst high at any time including mid-fetch or mid-redirect, immediately set state=BOOT, PC=RESET_PC, count=0, out_valid=0 and misalign=0.
REQ-030 SHALL treat buffer data contents as don't-care after reset; out_instr/out_pc SHALL be don't-care while out_valid=0.

Verification
REQ-031 SHALL cover: release rst, out_ready=1, mem[i]=i -> PC=0 in BOOT cycle; out_valid first high in cycle 2 with out_pc=0, then out_pc 4, 8, 12 on consecutive cycles.
REQ-032 SHALL cover: out_ready=0 for 5 cycles from RUN -> count saturates at 2 (pc 0, 4), PC holds at 8; out_ready=1 -> outputs 0, 4, 8 in order with no gap.
REQ-033 SHALL cover: redirect to 32'h100 while count==2 and pop=1 -> head pc popped, other entry dropped; next valid out_pc=32'h100, then 32'h104.
REQ-034 SHALL cover: redirect to 32'h202 -> PC=32'h200, misalign=1 and stays 1 after later aligned redirects.
REQ-035 SHALL cover: halt_req pulse with 2 buffered -> both drain, no new fetch, PC frozen; redir_valid to 32'h40 -> RUN, out_pc=32'h40.
REQ-036 SHALL cover: PC=32'hFFFF_FFFC fetch -> next out_pc=0; rst asserted mid-stream -> out_valid=0 and PC=RESET_PC asynchronously, before the next edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation, a 2-entry in-order
// {instr, pc} buffer toward decode, redirect/flush, halt, and misalign flag.
module fetch_ctrl #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(32'h0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_target,
  output logic [ADDR_WIDTH-1:0] PC,
  input  logic [ADDR_WIDTH-1:0] instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  misalign
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t                state;
  logic [1:0]            count;
  logic                  head;
  logic                  tail;
  logic                  pop;
  logic                  fetch;
  logic [ADDR_WIDTH-1:0] buf_instr [2];
  logic [ADDR_WIDTH-1:0] buf_pc    [2];

  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];
  assign pop       = out_valid && out_ready;

  // A halt request in RUN also suppresses the fetch of that cycle.
  assign fetch = (state == RUN) && !stall && !redir_valid && !halt_req &&
                 ((count != 2'd2) || pop);

  // Tail slot: with one entry it is the other slot; with 0 or 2 (2 only when
  // a pop frees the head this cycle) it is the head slot itself.
  assign tail = head ^ (count == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      PC       <= RESET_PC;
      count    <= 2'd0;
      head     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (!redir_valid && halt_req) state <= HALTED;
        HALTED:  if (redir_valid) state <= RUN;
        default: state <= BOOT;
      endcase

      if (pop) head <= ~head;

      if (redir_valid) begin
        count <= 2'd0;
        PC    <= {redir_target[ADDR_WIDTH-1:2], 2'b00};
        if (redir_target[1:0] != 2'b00) misalign <= 1'b1;
      end else begin
        if (fetch) PC <= PC + ADDR_WIDTH'(4);
        if (fetch && !pop)      count <= count + 2'd1;
        else if (pop && !fetch) count <= count - 2'd1;
      end
    end
  end

  // Buffer payload carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (fetch) begin
      buf_instr[tail] <= instr;
      buf_pc[tail]    <= PC;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, back-pressure, redirect flush,
// misalign, halt/drain, PC wrap, async reset, redirect in BOOT and stall.
module tb_fetch_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          halt_req;
  logic          redir_valid;
  logic [AW-1:0] redir_target;
  logic [AW-1:0] PC;
  logic [AW-1:0] instr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          misalign;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .redir_valid(redir_valid), .redir_target(redir_target), .PC(PC),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Combinational memory: mem[i] = i, i is the word index.
  assign instr = PC >> 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
    redir_target = '0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_misalign", 32'(misalign), 32'd0);

    // Boot sequence with decode always ready
    rst = 1'b0;
    check("boot_pc", PC, 32'h0);
    check("boot_valid", 32'(out_valid), 32'd0);
    tick();
    check("run1_valid", 32'(out_valid), 32'd0);
    tick();
    check("c2_valid", 32'(out_valid), 32'd1);
    check("c2_pc", out_pc, 32'h0);
    check("c2_instr", out_instr, 32'h0);
    tick();
    check("c3_pc", out_pc, 32'h4);
    check("c3_instr", out_instr, 32'h1);
    tick();
    check("c4_pc", out_pc, 32'h8);
    tick();
    check("c5_pc", out_pc, 32'hC);

    // Back-pressure: buffer saturates at two entries
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("sat_valid", 32'(out_valid), 32'd1);
    check("sat_head", out_pc, 32'h0);
    check("sat_pc", PC, 32'h8);
    out_ready = 1'b1;
    check("drain0", out_pc, 32'h0);
    tick();
    check("drain1", out_pc, 32'h4);
    tick();
    check("drain2", out_pc, 32'h8);
    check("drain2_pc", PC, 32'h10);

    // Redirect with full buffer and a same-cycle pop
    redir_valid = 1'b1; redir_target = 32'h100;
    tick();
    redir_valid = 1'b0;
    check("redir_flush", 32'(out_valid), 32'd0);
    check("redir_pc", PC, 32'h100);
    tick();
    check("redir_t0", out_pc, 32'h100);
    check("redir_t0_instr", out_instr, 32'h40);
    tick();
    check("redir_t1", out_pc, 32'h104);

    // Misaligned target is forced aligned and flagged sticky
    redir_valid = 1'b1; redir_target = 32'h202;
    tick();
    check("mis_pc", PC, 32'h200);
    check("mis_flag", 32'(misalign), 32'd1);
    redir_target = 32'h300;
    tick();
    redir_valid = 1'b0;
    check("mis_sticky", 32'(misalign), 32'd1);
    check("mis_pc2", PC, 32'h300);

    // Halt with two buffered entries
    out_ready = 1'b0;
    tick();
    tick();
    check("hlt_head", out_pc, 32'h300);
    check("hlt_pc0", PC, 32'h308);
    halt_req = 1'b1; out_ready = 1'b1;
    tick();
    halt_req = 1'b0;
    check("hlt_drain", out_pc, 32'h304);
    check("hlt_pc1", PC, 32'h308);
    tick();
    check("hlt_empty", 32'(out_valid), 32'd0);
    tick();
    tick();
    check("hlt_still_empty", 32'(out_valid), 32'd0);
    check("hlt_pc_frozen", PC, 32'h308);
    redir_valid = 1'b1; redir_target = 32'h40;
    tick();
    redir_valid = 1'b0;
    check("hlt_redir_pc", PC, 32'h40);
    tick();
    check("hlt_resume", out_pc, 32'h40);

    // PC wraps from the top of the address space
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    tick();
    check("wrap_top", out_pc, 32'hFFFF_FFFC);
    check("wrap_pcreg", PC, 32'h0);
    tick();
    check("wrap_zero", out_pc, 32'h0);
    check("wrap_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc", PC, 32'h0);
    check("arst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);

    // Redirect during BOOT, then stall behaviour
    rst = 1'b0; redir_valid = 1'b1; redir_target = 32'h80;
    tick();
    redir_valid = 1'b0; stall = 1'b1;
    check("boot_redir_pc", PC, 32'h80);
    check("boot_redir_valid", 32'(out_valid), 32'd0);
    tick();
    check("stall_nofetch", 32'(out_valid), 32'd0);
    check("stall_pc", PC, 32'h80);
    stall = 1'b0;
    tick();
    check("post_boot_pc", out_pc, 32'h80);
    check("post_boot_instr", out_instr, 32'h20);
    stall = 1'b1;
    tick();
    check("stall_pop", 32'(out_valid), 32'd0);
    check("stall_pc_hold", PC, 32'h84);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
